// File: rtl/jts16_colmix.sv
// rtl/jts16_colmix.sv - System 16 colour mixer: object/tile priority, shadow, shared palette, 5-bit RGB
// Optional JTS16_COLMIX_LAYER_EN adds gfx_en[1:0] (bit0 tiles, bit1 objects) layer enables.
module jts16_colmix #(
  parameter int BLNK_DLY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [11:0] obj_pxl,
  input  logic [10:0] tile_pxl,
`ifdef JTS16_COLMIX_LAYER_EN
  input  logic [1:0]  gfx_en,
`endif
  input  logic        pal_cs,
  input  logic [10:0] cpu_addr,
  input  logic [15:0] cpu_dout,
  input  logic [1:0]  dswn,
  output logic [15:0] cpu_din,
  output logic [4:0]  red,
  output logic [4:0]  green,
  output logic [4:0]  blue
);

  logic [1:0] layer_en;
`ifdef JTS16_COLMIX_LAYER_EN
  assign layer_en = gfx_en;
`else
  assign layer_en = 2'b11;
`endif

  logic [15:0] pal_mem [0:2047];

  logic [15:0]         cpu_din_q;
  logic [11:0]         obj_s1_q;
  logic [10:0]         tile_s1_q;
  logic [BLNK_DLY-1:0] vis_q;
  logic [10:0]         addr_d, addr_q;
  logic                shade_d, shade2_q, shade3_q;
  logic [14:0]         vid_q;
  logic [4:0]          red_d, green_d, blue_d;
  logic [4:0]          red_q, green_q, blue_q;

  // CPU side of the palette: byte-wise writes, never reset
  always_ff @(posedge clk) begin
    if (pal_cs && !dswn[1]) pal_mem[cpu_addr][15:8] <= cpu_dout[15:8];
    if (pal_cs && !dswn[0]) pal_mem[cpu_addr][7:0]  <= cpu_dout[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_din_q <= 16'd0;
    end else if (pal_cs) begin
      cpu_din_q <= pal_mem[cpu_addr];
    end
  end

  // S1: input capture plus the blank delay line (kept in step with the pixel latency)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      obj_s1_q  <= 12'd0;
      tile_s1_q <= 11'd0;
      vis_q     <= '0;
    end else if (pxl_cen) begin
      obj_s1_q  <= obj_pxl;
      tile_s1_q <= tile_pxl;
      vis_q     <= {vis_q[BLNK_DLY-2:0], LHBL & LVBL};
    end
  end

  logic [1:0] o_prio;
  logic [5:0] o_pal;
  logic [3:0] o_col;
  logic       t_prio;
  logic [6:0] t_pal;
  logic [2:0] t_col;
  logic       obj_op, obj_shd, tile_op, obj_win;
  logic [1:0] tile_lvl;

  assign {o_prio, o_pal, o_col} = obj_s1_q;
  assign {t_prio, t_pal, t_col} = tile_s1_q;

  assign obj_op   = layer_en[1] && (o_col != 4'h0) && (o_col != 4'hf);
  assign obj_shd  = obj_op && (o_pal == 6'h3f) && (o_col == 4'ha);
  assign tile_op  = layer_en[0] && (t_col != 3'd0);
  assign tile_lvl = t_prio ? 2'd3 : 2'd1;
  assign obj_win  = obj_op && (!tile_op || (o_prio >= tile_lvl));

  // A winning shadow pixel shows whatever lies beneath it, darkened
  always_comb begin
    addr_d  = 11'd0;
    shade_d = obj_win && obj_shd;
    if (obj_win && !obj_shd) begin
      addr_d = {1'b1, o_pal, o_col};
    end else if (tile_op) begin
      addr_d = {1'b0, t_pal, t_col};
    end
  end

  // S2 registers the address; S3 reads the palette, older word wins on a CPU collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= 11'd0;
      shade2_q <= 1'b0;
      shade3_q <= 1'b0;
      vid_q    <= 15'd0;
    end else if (pxl_cen) begin
      addr_q   <= addr_d;
      shade2_q <= shade_d;
      shade3_q <= shade2_q;
      vid_q    <= pal_mem[addr_q][14:0];
    end
  end

  always_comb begin
    red_d   = vid_q[4:0];
    green_d = vid_q[9:5];
    blue_d  = vid_q[14:10];
    if (shade3_q) begin
      red_d   = red_d   >> 1;
      green_d = green_d >> 1;
      blue_d  = blue_d  >> 1;
    end
    if (!vis_q[BLNK_DLY-1]) begin
      red_d   = 5'd0;
      green_d = 5'd0;
      blue_d  = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red_q   <= 5'd0;
      green_q <= 5'd0;
      blue_q  <= 5'd0;
    end else if (pxl_cen) begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign cpu_din = cpu_din_q;
  assign red     = red_q;
  assign green   = green_q;
  assign blue    = blue_q;

endmodule

// File: tb/tb_jts16_colmix.sv
// tb/tb_jts16_colmix.sv - self-checking bench for jts16_colmix
module tb_jts16_colmix;

  logic        clk;
  logic        rst;
  logic        pxl_cen;
  logic        LHBL;
  logic        LVBL;
  logic [11:0] obj_pxl;
  logic [10:0] tile_pxl;
  logic        pal_cs;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_dout;
  logic [1:0]  dswn;
  logic [15:0] cpu_din;
  logic [4:0]  red;
  logic [4:0]  green;
  logic [4:0]  blue;

  jts16_colmix #(.BLNK_DLY(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .obj_pxl  (obj_pxl),
    .tile_pxl (tile_pxl),
    .pal_cs   (pal_cs),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .dswn     (dswn),
    .cpu_din  (cpu_din),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] obj;
    logic [10:0] tile;
    logic        hb;
    logic        vb;
    logic [14:0] rgb;
  } vec_t;

  vec_t        vt [0:12];
  int          n_vec;
  int          n_bad;
  logic [15:0] pal_m [0:2047];
  logic [14:0] exp_q [$];
  logic [14:0] exp_rgb;
  bit          model_on;
  logic [15:0] rd;
  logic [31:0] rnd;

  function automatic logic [15:0] rgb16();
    return {1'b0, red, green, blue};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %04h expected %04h", name, act, exp);
    end
  endtask

  // Reference: choose the visible palette entry from the layer rules, then darken/blank it
  function automatic logic [14:0] ref_rgb(input logic [11:0] o, input logic [10:0] t, input logic vis);
    int  oprio, opal, ocol, tprio, tpal, tcol, level, idx, w, r, g, b;
    bit  ovis, shadow, tvis, obj_top;
    oprio = int'(o[11:10]);
    opal  = int'(o[9:4]);
    ocol  = int'(o[3:0]);
    tprio = int'(t[10]);
    tpal  = int'(t[9:3]);
    tcol  = int'(t[2:0]);
    ovis    = (ocol != 0) && (ocol != 15);
    shadow  = ovis && (opal == 63) && (ocol == 10);
    tvis    = (tcol != 0);
    level   = (tprio == 1) ? 3 : 1;
    obj_top = ovis && (!tvis || oprio >= level);
    if (!vis) return 15'd0;
    if (obj_top && !shadow) idx = 1024 + opal * 16 + ocol;
    else if (tvis)          idx = tpal * 8 + tcol;
    else                    idx = 0;
    w = int'(pal_m[idx[10:0]]);
    r = w % 32;
    g = (w / 32) % 32;
    b = (w / 1024) % 32;
    if (obj_top && shadow) begin
      r = r / 2;
      g = g / 2;
      b = b / 2;
    end
    return {r[4:0], g[4:0], b[4:0]};
  endfunction

  task automatic tick(input bit cen);
    pxl_cen = cen;
    @(posedge clk);
    if (cen && model_on) begin
      exp_q.push_back(ref_rgb(obj_pxl, tile_pxl, LHBL & LVBL));
      exp_rgb = exp_q.pop_front();
    end
    @(negedge clk);
    pxl_cen = 1'b0;
  endtask

  task automatic cpu_wr(input logic [10:0] a, input logic [15:0] d, input logic [1:0] be_n);
    pal_cs = 1'b1; cpu_addr = a; cpu_dout = d; dswn = be_n;
    @(posedge clk);
    @(negedge clk);
    pal_cs = 1'b0; dswn = 2'b11;
    if (!be_n[1]) pal_m[a][15:8] = d[15:8];
    if (!be_n[0]) pal_m[a][7:0]  = d[7:0];
  endtask

  task automatic cpu_rd(input logic [10:0] a, output logic [15:0] d);
    pal_cs = 1'b1; dswn = 2'b11; cpu_addr = a;
    @(posedge clk);
    @(negedge clk);
    d = cpu_din;
    pal_cs = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_bad = 0; model_on = 0; exp_rgb = 15'd0;
    vt[0]  = '{12'h000, 11'h0a3, 1'b1, 1'b1, {5'd31, 5'd0,  5'd0}};
    vt[1]  = '{12'h857, 11'h40a, 1'b1, 1'b1, {5'd0,  5'd31, 5'd0}};
    vt[2]  = '{12'hc57, 11'h40a, 1'b1, 1'b1, {5'd0,  5'd0,  5'd31}};
    vt[3]  = '{12'h85f, 11'h400, 1'b1, 1'b1, {5'd3,  5'd3,  5'd3}};
    vt[4]  = '{12'h850, 11'h0a0, 1'b1, 1'b1, {5'd3,  5'd3,  5'd3}};
    vt[5]  = '{12'hffa, 11'h115, 1'b1, 1'b1, {5'd15, 5'd5,  5'd0}};
    vt[6]  = '{12'hffa, 11'h110, 1'b1, 1'b1, {5'd1,  5'd1,  5'd1}};
    vt[7]  = '{12'h000, 11'h0a3, 1'b0, 1'b1, {5'd0,  5'd0,  5'd0}};
    vt[8]  = '{12'h000, 11'h0a3, 1'b1, 1'b0, {5'd0,  5'd0,  5'd0}};
    vt[9]  = '{12'h457, 11'h00a, 1'b1, 1'b1, {5'd0,  5'd0,  5'd31}};
    vt[10] = '{12'h057, 11'h00a, 1'b1, 1'b1, {5'd0,  5'd31, 5'd0}};
    vt[11] = '{12'h057, 11'h408, 1'b1, 1'b1, {5'd0,  5'd0,  5'd31}};
    vt[12] = '{12'h85f, 11'h0a3, 1'b1, 1'b1, {5'd31, 5'd0,  5'd0}};

    rst = 1'b0; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    obj_pxl = 12'd0; tile_pxl = 11'd0;
    pal_cs = 1'b0; cpu_addr = 11'd0; cpu_dout = 16'd0; dswn = 2'b11;
    repeat (3) @(negedge clk);
    check("reset_rgb", rgb16(), 16'd0);
    check("reset_cpu_din", cpu_din, 16'd0);
    rst = 1'b1;
    @(negedge clk);

    // CPU port
    cpu_wr(11'h005, 16'h7fff, 2'b00);
    cpu_rd(11'h005, rd);
    check("cpu_full_write", rd, 16'h7fff);
    cpu_wr(11'h005, 16'h1234, 2'b10);
    cpu_rd(11'h005, rd);
    check("cpu_low_byte", rd, 16'h7f34);
    cpu_addr = 11'h0a3;
    @(posedge clk);
    @(negedge clk);
    check("cpu_din_hold", cpu_din, 16'h7f34);

    cpu_wr(11'h000, 16'h0c63, 2'b00);
    cpu_wr(11'h0a3, 16'h001f, 2'b00);
    cpu_wr(11'h00a, 16'h03e0, 2'b00);
    cpu_wr(11'h457, 16'h7c00, 2'b00);
    cpu_wr(11'h115, 16'h055f, 2'b00);

    // Table: hold each vector for 4 pixel ticks, output then reflects it
    for (int i = 0; i < 13; i++) begin
      obj_pxl = vt[i].obj; tile_pxl = vt[i].tile; LHBL = vt[i].hb; LVBL = vt[i].vb;
      repeat (4) tick(1'b1);
      check($sformatf("vec%0d", i), rgb16(), {1'b0, vt[i].rgb});
    end

    // Exact latency and stall behaviour
    LHBL = 1'b0;
    repeat (4) tick(1'b1);
    check("lat_blank", rgb16(), 16'd0);
    LHBL = 1'b1; obj_pxl = 12'h000; tile_pxl = 11'h0a3;
    tick(1'b1);
    LHBL = 1'b0;
    tick(1'b1);
    check("lat_n1", rgb16(), 16'd0);
    repeat (3) tick(1'b0);
    check("lat_stall", rgb16(), 16'd0);
    tick(1'b1);
    check("lat_n2", rgb16(), 16'd0);
    tick(1'b1);
    check("lat_n3", rgb16(), {1'b0, 5'd31, 5'd0, 5'd0});
    repeat (2) tick(1'b0);
    check("lat_hold", rgb16(), {1'b0, 5'd31, 5'd0, 5'd0});

    // Video read and CPU write on the same address in the same clock
    LHBL = 1'b1; obj_pxl = 12'h000; tile_pxl = 11'h0a3;
    tick(1'b1);
    tick(1'b1);
    pal_cs = 1'b1; cpu_addr = 11'h0a3; cpu_dout = 16'h03e0; dswn = 2'b00;
    tick(1'b1);
    pal_cs = 1'b0; dswn = 2'b11; pal_m[11'h0a3] = 16'h03e0;
    tick(1'b1);
    check("collision_old", rgb16(), {1'b0, 5'd31, 5'd0, 5'd0});
    tick(1'b1);
    check("collision_new", rgb16(), {1'b0, 5'd0, 5'd31, 5'd0});

    // Reset mid-line
    #2;
    rst = 1'b0;
    #1;
    check("midreset_rgb", rgb16(), 16'd0);
    check("midreset_cpu_din", cpu_din, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(1'b1);
      check($sformatf("refill%0d", k), rgb16(), 16'd0);
    end
    tick(1'b1);
    check("refill4", rgb16(), {1'b0, 5'd0, 5'd31, 5'd0});
    cpu_rd(11'h115, rd);
    check("pal_kept_115", rd, 16'h055f);
    cpu_rd(11'h005, rd);
    check("pal_kept_005", rd, 16'h7f34);

    // Randomised palette and pixels against the reference model
    pal_cs = 1'b1; dswn = 2'b00;
    for (int i = 0; i < 2048; i++) begin
      rnd = $urandom();
      cpu_addr = i[10:0]; cpu_dout = rnd[15:0]; pal_m[i[10:0]] = rnd[15:0];
      @(posedge clk);
      @(negedge clk);
    end
    pal_cs = 1'b0; dswn = 2'b11;
    for (int i = 0; i < 8; i++) begin
      rnd = $urandom();
      cpu_rd(rnd[10:0], rd);
      check("rand_cpu_rd", rd, pal_m[rnd[10:0]]);
    end

    LHBL = 1'b0;
    repeat (4) tick(1'b1);
    exp_q.delete();
    repeat (3) exp_q.push_back(15'd0);
    exp_rgb = 15'd0;
    model_on = 1;
    for (int i = 0; i < 1500; i++) begin
      rnd = $urandom();
      obj_pxl = rnd[11:0];
      tile_pxl = rnd[22:12];
      if (rnd[25:23] == 3'd0) obj_pxl[9:0] = 10'h3fa;
      LHBL = (rnd[29:26] != 4'd0);
      LVBL = (rnd[31:30] != 2'd0) || (i % 7 != 0);
      tick($urandom_range(2, 0) != 0);
      check("random", rgb16(), {1'b0, exp_rgb});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jts16_colmix.md
Name: jts16_colmix

Overview:
- Colour mixer directly downstream of the System 16 object line buffer and the tilemap renderers.
- Each pixel: resolves object vs tile priority, applies object shadow, and looks up a 2048-entry palette RAM shared with the CPU.
- Outputs 5-bit RGB to the video output stage.
- Pipelined on pxl_cen; fixed latency of 3 pixel ticks.

Parameters:
- BLNK_DLY, 3, pixel ticks of delay applied to LHBL/LVBL; must equal the pixel latency so blanking stays aligned.

Ports:
- clk  in  1  system clock (one clock).
- rst  in  1  reset, asynchronous, active-low.
- pxl_cen  in  1  pixel clock enable.
- LHBL  in  1  horizontal blank, active low.
- LVBL  in  1  vertical blank, active low.
- obj_pxl  in  12  {prio[1:0], pal[5:0], col[3:0]} from the object line buffer.
- tile_pxl  in  11  {prio, pal[6:0], col[2:0]} from the merged tilemap layers.
- pal_cs  in  1  CPU palette chip select.
- cpu_addr  in  11  CPU word address, bits [11:1].
- cpu_dout  in  16  CPU write data.
- dswn  in  2  active-low byte write strobes, {upper, lower}.
- cpu_din  out  16  palette read data.
- red  out  5  output colour.
- green  out  5  output colour.
- blue  out  5  output colour.

Behaviour:
- Reset: red/green/blue/cpu_din = 0; all pipeline registers and the blank delay line cleared. Palette contents are not cleared. Reset may assert mid-line; the first pixels after release read 0 until the pipeline refills.

Palette RAM:
- 2048x16, dual port; entry bits [4:0] R, [9:5] G, [14:10] B, [15] stored but unused.

CPU port (any clk, independent of pxl_cen):
- Write when pal_cs=1 and a dswn bit is low; dswn[1] writes bits [15:8], dswn[0] writes [7:0].
- cpu_din is the registered read of cpu_addr, valid 1 clk after the address; it holds its value while pal_cs=0.

Video port (read only):
- Read-before-write: on a same-clk collision the video read returns the old word.

Pipeline, advancing only on pxl_cen:
- S1: register obj_pxl, tile_pxl and the blank state (LHBL & LVBL).
- S2: layer select. Then compute the palette address and the shadow flag.
  - obj opaque: col ∉ {0, 15}. tile opaque: col != 0.
  - shadow pixel: obj pal = 6'h3f and col = 4'ha; it counts as opaque for priority.
  - Tile level L = 3 if tile prio=1, otherwise 1.
  - obj wins if obj is opaque and (tile is transparent or obj_prio >= L).
  - tile wins if tile is opaque and obj does not win.
  - Neither opaque: address 0.
  - Address: tile {1'b0, pal, col}; obj {1'b1, pal, col}.
  - For a winning shadow pixel: the address is the underlying tile (or 0) and shadow=1.
- S3: palette RAM read (1-clk RAM latency, captured by the next pxl_cen).
- Output stage:
  - Channel value = word field, or field>>1 (floor) when shadow=1.
  - Forced to 0 when the delayed blank is active.
  - Registered into red/green/blue on pxl_cen.

Latency and timing:
- Input sampled at pxl_cen edge n appears on the outputs after edge n+3.
- Outputs are stable between pxl_cen pulses.
- pxl_cen gaps do not corrupt data; the pipeline simply stalls.
- There is no back-pressure.

Optional Feature:
- Macro: JTS16_COLMIX_LAYER_EN.
- When defined: adds input port gfx_en[1:0] (bit0 = tiles, bit1 = objects). A cleared bit forces that layer transparent at S2; a shadow pixel is dropped when objects are disabled.
- When undefined: the port is absent and both layers are always enabled. Behaviour is otherwise identical.

Test Plan:
- CPU path: write 16'h7fff to address 0x005 with dswn=2'b00 and read it back → cpu_din=16'h7fff one clk later. Then write 16'h1234 with dswn=2'b10 and read back → cpu_din=16'h7f34.
- Tile only: palette[0x0a3]=16'h001f; tile_pxl={0, 7'h14, 3'h3}, obj col=0 → red=31, green=0, blue=0 exactly 3 pxl_cen after the input.
- Priority: tile {1, 7'h01, 3'h2} with obj {2'd2, 6'h05, 4'h7} → tile palette 0x00a shown. Same test with obj prio 3 → palette 0x457 shown.
- Transparency/background: obj col=15 and tile col=0 → palette[0x000] output. Both col=0 → palette[0x000] output.
- Shadow: obj {3, 6'h3f, 4'ha} over a tile whose colour is R=31, G=10, B=1 → output R=15, G=5, B=0.
- Blanking/reset: LHBL=0 → RGB=0 three ticks later. rst asserted mid-line → outputs 0 immediately and the palette is preserved. Video/CPU collision on the same address → video gets the old word.
